// File: rtl/mac_lane_array_if.sv
// Job/beat/result bus for mac_lane_array: job start, operand stream, result handshake.
interface mac_lane_array_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 18,
  parameter int OUT_W  = 18,
  parameter int LEN_W  = 10
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic [7:0]                exp;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_single;
  logic [LANES*DATA_W-1:0]   in_pack;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*OUT_W-1:0]    out_pack;
  logic                      busy;

  // Job source / result sink side.
  modport master (
    output start, len, exp, in_valid, in_single, in_pack, out_ready,
    input  in_ready, out_valid, out_pack, busy
  );

  // MAC array side.
  modport slave (
    input  start, len, exp, in_valid, in_single, in_pack, out_ready,
    output in_ready, out_valid, out_pack, busy
  );
endinterface

// File: rtl/mac_lane_array.sv
// Broadcast-operand multiply-accumulate array: every lane accumulates in_single*weight
// over a job of len beats, then emits a power-of-two scaled, saturated result.

// One lane: product register, wrapping accumulator, scale+saturate output register.
module mac_lane #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 46,
  parameter int OUT_W  = 18
) (
  input  logic                     clk_pll,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     fire,
  input  logic                     pvld,
  input  logic                     scale,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [7:0]        exp_q,
  output logic [OUT_W-1:0]         res
);
  localparam int PW = 2*DATA_W;
  localparam int WW = ACC_W + OUT_W;
  localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [WW-1:0]    ext, wide;
  logic [OUT_W-1:0]        sat_v;
  int                      e;

  // Capture the full-width product of each accepted beat.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n)    prod <= '0;
    else if (fire) prod <= PW'(a) * PW'(b);
  end

  // Fold the registered product into the accumulator; wraps naturally at ACC_W.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (clr)  acc <= '0;
    else if (pvld) acc <= acc + ACC_W'(prod);
  end

  // Scale by 2^exp then clamp. Left shifts are capped at OUT_W: any nonzero value
  // shifted that far already saturates, and the result still fits in WW bits.
  // Right shifts are capped at ACC_W-1, which already yields pure sign fill.
  always_comb begin
    e   = int'(exp_q);
    ext = WW'(acc);
    if (e >= 0) wide = ext <<< ((e > OUT_W) ? OUT_W : e);
    else        wide = ext >>> ((-e > ACC_W-1) ? ACC_W-1 : -e);
    if (wide > MAXV)      sat_v = MAXV[OUT_W-1:0];
    else if (wide < MINV) sat_v = MINV[OUT_W-1:0];
    else                  sat_v = wide[OUT_W-1:0];
  end

  // Result register, loaded once per job and held afterwards.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n)     res <= '0;
    else if (scale) res <= sat_v;
  end
endmodule

module mac_lane_array #(
  parameter int LANES  = 16,
  parameter int DATA_W = 18,
  parameter int ACC_W  = 46,
  parameter int OUT_W  = 18,
  parameter int LEN_W  = 10
) (
  input  logic            clk_pll,
  input  logic            rst_n,
  mac_lane_array_if.slave bus
);
  if (ACC_W < 2*DATA_W + LEN_W) begin : g_bad_acc_w
    $error("mac_lane_array: ACC_W must be >= 2*DATA_W+LEN_W");
  end

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] SCALE = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]        state;
  logic [LEN_W-1:0]  cnt;
  logic signed [7:0] exp_q;
  logic              out_valid_q;
  logic              pvld;
  logic              fire, clr, scale;
  logic [OUT_W-1:0]  res [LANES];

  assign fire          = (state == ACCUM) && bus.in_valid;
  assign clr           = (state == IDLE) && bus.start;
  assign scale         = (state == SCALE);
  assign bus.in_ready  = (state == ACCUM);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;

  // Product register holds a fresh beat for exactly one cycle after each handshake.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) pvld <= 1'b0;
    else        pvld <= fire;
  end

  // Job sequencing: IDLE -> ACCUM (len beats) -> FLUSH -> SCALE -> OUT.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      exp_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          exp_q <= bus.exp;
          cnt   <= bus.len;
          state <= (bus.len != '0) ? ACCUM : SCALE;
        end
        ACCUM: if (fire) begin
          cnt <= cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state <= FLUSH;
        end
        FLUSH: state <= SCALE;
        SCALE: begin
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
      .clk_pll (clk_pll),
      .rst_n   (rst_n),
      .clr     (clr),
      .fire    (fire),
      .pvld    (pvld),
      .scale   (scale),
      .a       (bus.in_single),
      .b       (bus.in_pack[gi*DATA_W +: DATA_W]),
      .exp_q   (exp_q),
      .res     (res[gi])
    );
  end

  // Pack lane results with the same lane order as in_pack.
  always_comb begin
    bus.out_pack = '0;
    for (int i = 0; i < LANES; i++) bus.out_pack[i*OUT_W +: OUT_W] = res[i];
  end
endmodule

// File: doc/mac_lane_array.md
MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

Interface
REQ-001 SHALL have parameter LANES, default 16, number of parallel lanes (>=1).
REQ-002 SHALL have parameter DATA_W, default 18, signed two's-complement operand width.
REQ-003 SHALL have parameter ACC_W, default 46, accumulator width; SHALL require ACC_W >= 2*DATA_W+LEN_W.
REQ-004 SHALL have parameter OUT_W, default 18, signed result width per lane.
REQ-005 SHALL have parameter LEN_W, default 10, beat-count width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset; all state changes on the rising edge of clk_pll.
REQ-007 clk_pll  input  1  clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 start  input  1  begin job; sampled only in IDLE.
REQ-010 len  input  LEN_W  beats per job, latched at start.
REQ-011 exp  input  8  signed power-of-two output scale, latched at start.
REQ-012 in_valid  input  1  beat offered.
REQ-013 in_ready  output  1  beat accepted when in_valid and in_ready are both high at an edge.
REQ-014 in_single  input  DATA_W  broadcast operand.
REQ-015 in_pack  input  LANES*DATA_W  per-lane weights; lane i at bits [i*DATA_W +: DATA_W].
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 out_pack  output  LANES*OUT_W  per-lane results, same lane packing as in_pack.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, FLUSH, SCALE, OUT.
REQ-021 IDLE: start=1 with len>0 SHALL clear all accumulators, load the beat counter with len, latch exp, and go to ACCUM.
REQ-022 IDLE: start=1 with len=0 SHALL clear all accumulators and go directly to SCALE.
REQ-023 in_ready SHALL be high only in ACCUM.
REQ-024 Each accepted beat SHALL register the per-lane product in_single*weight_i (full 2*DATA_W signed width) into a product register.
REQ-025 The registered product SHALL be added, sign-extended, into the lane accumulator on the following edge.
REQ-026 Accumulators SHALL wrap modulo 2^ACC_W.
REQ-027 Cycles in ACCUM without a handshake SHALL leave the counter and accumulators unchanged.
REQ-028 The handshake that accepts the final beat SHALL move the FSM to FLUSH.
REQ-029 FLUSH SHALL last one cycle, absorb the last product, and go to SCALE.
REQ-030 SCALE SHALL last one cycle and register out_pack = sat(acc scaled by exp), set out_valid, and go to OUT.
REQ-031 Result: out_valid SHALL be high 2 cycles after the final beat handshake edge.
REQ-032 Scaling, exp>=0: SHALL shift left by exp.
REQ-033 Scaling, exp<0: SHALL arithmetic-shift right by -exp, truncating toward minus infinity; a shift >= ACC_W SHALL yield 0 or -1 by sign.
REQ-034 Saturation: each lane SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], including overflow caused by a left shift.
REQ-035 OUT: out_pack and out_valid SHALL hold stable until out_ready=1.
REQ-036 OUT: on out_ready=1 the block SHALL clear out_valid and go to IDLE; out_pack SHALL retain its value.
REQ-037 start SHALL be ignored in every state other than IDLE.
REQ-038 in_valid SHALL be ignored outside ACCUM.

Reset
REQ-039 rst_n low SHALL immediately force: state IDLE, in_ready 0, out_valid 0, busy 0, out_pack 0, accumulators 0, product registers 0, counter 0.
REQ-040 Reset mid-job SHALL abort the job with no result emitted; the next start after release SHALL run normally.

Verification
REQ-041 LANES=4, len=3, exp=0, in_single=2, all weights 3, three back-to-back beats -> out_valid 2 cycles after the third handshake, every lane 18.
REQ-042 Same job with exp=-2 -> lanes 4; weights -3 with exp=-2 -> lanes -5.
REQ-043 len=4, in_single=131071, weights 131071 / -131071 -> lanes 131071 / -131072 (saturated).
REQ-044 in_valid gapped 1-of-3 cycles and out_ready held low 5 cycles after out_valid -> result identical to the ungapped run; out_pack stable while waiting.
REQ-045 len=0 start -> out_valid 2 edges after start, all lanes 0; a start pulse during ACCUM -> no effect.
REQ-046 rst_n low after the second of three beats -> all outputs 0 at once, no out_valid; a fresh job afterwards is correct.
